sopc_2_button_pio: RTL and testbench
====================================

// Module: sopc_2_button_pio
// PURPOSE
//   Parametrised Avalon-MM input PIO for push-buttons/switches: WIDTH inputs, 2-flop synchroniser,
//   optional per-bit debounce, per-bit rising/falling edge select, per-bit edge capture with
//   write-1-to-clear and maskable level IRQ. Sits on the SOPC system bus as an s1 slave.
// PARAMETERS
//   WIDTH        4      number of input bits (1..32)
//   DEB_CYCLES   50000  clk cycles an input must be stable before accepted (debounce only, >=2)
//   DEB_CW       16     debounce counter width; must satisfy 2**DEB_CW > DEB_CYCLES
//   ANY_EDGE     0      1: capture both edges on every bit, edge_pol register ignored (reads 0)
// PORTS
//   clk         in   1      system clock
//   reset       in   1      asynchronous, active-high reset
//   address     in   2      register select (word address)
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data
//   in_port     in   WIDTH  raw asynchronous button inputs
//   readdata    out  32     registered read data
//   irq         out  1      level interrupt, active-high
// BEHAVIOUR
//   Register map (bits above WIDTH read 0, writes ignored):
//     0 DATA      RO   filtered input value (din)
//     1 EDGE_POL  RW   per bit: 0 = rising edge, 1 = falling edge
//     2 IRQ_MASK  RW   per bit interrupt enable
//     3 EDGE_CAP  R/W1C per bit sticky edge flag; writing 1 clears, 0 leaves unchanged
//   Reset: readdata=0, irq=0, sync flops=0, din=0, prev=0, edge_pol=0, irq_mask=0, edge_cap=0,
//     debounce counters=0. Reset mid-debounce aborts the count; no edge is flagged on release.
//   Input path: in_port -> s1 -> s2 (2-flop sync); din = debounced or raw s2; prev <= din each clk.
//   Edge detect (combinational): rise = din & ~prev, fall = ~din & prev;
//     hit[i] = ANY_EDGE ? rise|fall : (edge_pol[i] ? fall : rise).
//   Edge capture: edge_cap[i] <= hit[i] | (edge_cap[i] & ~w1c[i]); w1c = writedata on an address-3
//     write. Simultaneous hit and W1C on same bit: hit wins, bit stays 1 (no lost edge).
//   Write: chipselect & ~write_n, takes effect next clk edge; no wait states.
//   Read: readdata <= mux(address) every clk (not gated by chipselect); 1-cycle read latency.
//     Read of EDGE_CAP does not clear it.
//   irq = |(edge_cap & irq_mask), registered-source combinational; deasserts the cycle after the
//     clearing write or mask write.
//   Changing EDGE_POL does not itself generate an edge; only din transitions do.
//   Latency raw in_port change -> edge_cap set: 3 clk without debounce (s1, s2, capture).
// CONFIGURATION
//   Macro BUTTON_PIO_DEBOUNCE_EN:
//     defined: per-bit counter cnt[i]. If s2[i]==din[i] cnt[i]<=0; else cnt[i]<=cnt[i]+1 and when
//       cnt[i]==DEB_CYCLES-1 then din[i]<=s2[i], cnt[i]<=0. Any glitch shorter than DEB_CYCLES
//       clk resets the count; din never changes. Latency in_port -> edge_cap: DEB_CYCLES+3 clk.
//       Counter never wraps (bounded by DEB_CYCLES-1).
//     undefined: din = s2, no counters synthesised; DEB_CYCLES/DEB_CW unused.
// TESTING (WIDTH=4, DEB_CYCLES=8 for debounce builds)
//   1 Reset: assert reset async mid-cycle -> readdata=0, irq=0, all registers read 0 after release.
//   2 Rising edge: IRQ_MASK=4'hF, in_port 0->4'b0010 -> EDGE_CAP=4'h2 after 3 clk, irq=1;
//     DATA reads 4'h2 (1 clk read latency); write 4'h2 to addr 3 -> EDGE_CAP=0, irq=0 next clk.
//   3 Falling select: EDGE_POL=4'h1, in_port bit0 1->0 -> EDGE_CAP=4'h1; bit0 0->1 -> no capture;
//     with ANY_EDGE=1 both transitions capture.
//   4 Clear/set collision: W1C of bit1 in same cycle bit1 edge is detected -> EDGE_CAP[1]=1, irq
//     stays 1; W1C of 4'h0 leaves EDGE_CAP unchanged.
//   5 Mask: IRQ_MASK=4'h0, edge on bit3 -> EDGE_CAP=4'h8, irq=0; write IRQ_MASK=4'h8 -> irq=1.
//   6 Debounce (macro defined): 5-clk pulse on bit0 -> DATA stays 0, no capture; 12-clk high ->
//     DATA=1 and EDGE_CAP=4'h1 exactly 11 clk after in_port change.

Source files
------------

// File: rtl/sopc_2_button_pio.sv
// Avalon-MM input PIO for buttons/switches: 2-flop sync, optional debounce
// (macro BUTTON_PIO_DEBOUNCE_EN), edge select, W1C edge capture, masked IRQ.
//
// Ports:
//   clk, reset (async, active-high)
//   address[1:0], chipselect, write_n, writedata[31:0] : s1 slave write side
//   readdata[31:0] : registered read data, 1-cycle latency
//   in_port[WIDTH-1:0] : raw asynchronous inputs
//   irq : level interrupt = |(edge_cap & irq_mask)
// Register map: 0 DATA (RO), 1 EDGE_POL, 2 IRQ_MASK, 3 EDGE_CAP (W1C)

module sopc_2_button_pio #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_CW     = 16,
    parameter int ANY_EDGE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] pol_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_d;
    logic [31:0]      rd_q;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= in_port;
            s2_q   <= s1_q;
            prev_q <= din;
        end
    end

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam logic [DEB_CW-1:0] DEB_LAST = DEB_CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0]  din_q;
    logic [DEB_CW-1:0] cnt_q [WIDTH];

    // Count consecutive cycles the synchronised input disagrees with din;
    // any agreement (glitch ends) restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_q[i] == din_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DEB_LAST) begin
                    din_q[i] <= s2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DEB_CW'(1);
                end
            end
        end
    end

    assign din = din_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, writedata};
`else
    assign din = s2_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, writedata, DEB_CYCLES > 0, DEB_CW > 0};
`endif

    always_comb begin
        rise = din & ~prev_q;
        fall = ~din & prev_q;
        if (ANY_EDGE != 0) begin
            hit = rise | fall;
        end else begin
            hit = (pol_q & fall) | (~pol_q & rise);
        end
        w1c = (wr_en && address == 2'd3) ? wdata : '0;
        // A new edge wins over a simultaneous clear so no edge is lost.
        cap_d = hit | (cap_q & ~w1c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pol_q  <= '0;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            if (wr_en && address == 2'd1) begin
                pol_q <= wdata;
            end
            if (wr_en && address == 2'd2) begin
                mask_q <= wdata;
            end
            cap_q <= cap_d;
        end
    end

    // Read mux is not gated by chipselect; readdata tracks address each clk.
    always_comb begin
        rd_d = '0;
        unique case (address)
            2'd0: rd_d[WIDTH-1:0] = din;
            2'd1: rd_d[WIDTH-1:0] = (ANY_EDGE != 0) ? '0 : pol_q;
            2'd2: rd_d[WIDTH-1:0] = mask_q;
            2'd3: rd_d[WIDTH-1:0] = cap_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign readdata = rd_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_sopc_2_button_pio.sv
// Bench for sopc_2_button_pio: directed steps plus random traffic against
// a reference model; two instances cover selectable-edge and any-edge modes.

module tb_sopc_2_button_pio;

    localparam int W   = 4;
    localparam int DEB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd0;
    logic [31:0]   rd1;
    logic          irq0;
    logic          irq1;

    int checks = 0;
    int errors = 0;

    // Model state: h0/h1/h2 are the last three sampled in_port values.
    // The filtered input lags in_port by two samples, its history by three.
    logic [W-1:0]  h0, h1, h2;
    logic [W-1:0]  m_pol, m_mask;
    logic [W-1:0]  m_cap [2];
    logic [31:0]   m_rd [2];

    sopc_2_button_pio #(
        .WIDTH(W), .DEB_CYCLES(DEB), .DEB_CW(4), .ANY_EDGE(0)
    ) u_sel (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    sopc_2_button_pio #(
        .WIDTH(W), .DEB_CYCLES(DEB), .DEB_CW(4), .ANY_EDGE(1)
    ) u_any (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        h0 = '0; h1 = '0; h2 = '0;
        m_pol = '0; m_mask = '0;
        for (int k = 0; k < 2; k++) begin
            m_cap[k] = '0;
            m_rd[k]  = '0;
        end
    endtask

    task automatic tick();
        logic [W-1:0] hit;
        logic [W-1:0] w1c;
        logic         wr;
        @(posedge clk);
        wr  = chipselect && !write_n;
        w1c = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        for (int k = 0; k < 2; k++) begin
            case (address)
                2'd0: m_rd[k] = 32'(h1);
                2'd1: m_rd[k] = (k == 1) ? 32'd0 : 32'(m_pol);
                2'd2: m_rd[k] = 32'(m_mask);
                default: m_rd[k] = 32'(m_cap[k]);
            endcase
            hit = '0;
            for (int i = 0; i < W; i++) begin
                // Edge happened if the level changed; it counts if any-edge
                // or the new level is 1 for rising / 0 for falling.
                if (h1[i] != h2[i])
                    hit[i] = (k == 1) || (h1[i] != m_pol[i]);
            end
            m_cap[k] = hit | (m_cap[k] & ~w1c);
        end
        if (wr && address == 2'd1) m_pol = writedata[W-1:0];
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        h2 = h1;
        h1 = h0;
        h0 = in_port;
        @(negedge clk);
`ifndef BUTTON_PIO_DEBOUNCE_EN
        chk("model_rd_sel", rd0, m_rd[0]);
        chk("model_rd_any", rd1, m_rd[1]);
        chk("model_irq_sel", 32'(irq0), 32'(|(m_cap[0] & m_mask)));
        chk("model_irq_any", 32'(irq1), 32'(|(m_cap[1] & m_mask)));
`endif
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_rd_sel", rd0, 32'd0);
        chk("rst_async_rd_any", rd1, 32'd0);
        chk("rst_async_irq_sel", 32'(irq0), 32'd0);
        chk("rst_async_irq_any", 32'(irq1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Make outputs nonzero, then reset asynchronously mid-cycle.
        wr(2'd2, 32'hF);
        in_port = 4'h3;
        repeat (4) tick();
        in_port = 4'h0;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            chk("rst_reg_sel", rd0, 32'd0);
            chk("rst_reg_any", rd1, 32'd0);
        end

`ifdef BUTTON_PIO_DEBOUNCE_EN
        wr(2'd2, 32'hF);
        in_port = 4'h1;
        repeat (5) tick();
        in_port = 4'h0;
        repeat (20) tick();
        rd(2'd0);
        chk("deb_glitch_data", rd0, 32'd0);
        rd(2'd3);
        chk("deb_glitch_cap", rd0, 32'd0);
        chk("deb_glitch_irq", 32'(irq0), 32'd0);
        in_port = 4'h1;
        repeat (10) tick();
        chk("deb_irq_early", 32'(irq0), 32'd0);
        tick();
        chk("deb_irq_11clk", 32'(irq0), 32'd1);
        rd(2'd3);
        chk("deb_cap", rd0, 32'h1);
        rd(2'd0);
        chk("deb_data", rd0, 32'h1);
`else
        // Rising edge with 3-clk latency, then W1C.
        wr(2'd2, 32'hF);
        in_port = 4'h2;
        tick();
        tick();
        chk("rise_irq_early", 32'(irq0), 32'd0);
        tick();
        chk("rise_irq", 32'(irq0), 32'd1);
        rd(2'd3);
        chk("rise_cap", rd0, 32'h2);
        rd(2'd0);
        chk("rise_data", rd0, 32'h2);
        wr(2'd3, 32'h2);
        chk("w1c_irq", 32'(irq0), 32'd0);
        rd(2'd3);
        chk("w1c_cap", rd0, 32'h0);

        // Clear in the same cycle as a new edge: the edge wins.
        in_port = 4'h0;
        repeat (4) tick();
        in_port = 4'h2;
        tick();
        tick();
        wr(2'd3, 32'h2);
        chk("coll_irq_sel", 32'(irq0), 32'd1);
        chk("coll_irq_any", 32'(irq1), 32'd1);
        rd(2'd3);
        chk("coll_cap", rd0, 32'h2);
        wr(2'd3, 32'h0);
        rd(2'd3);
        chk("w1c_zero_cap", rd0, 32'h2);
        wr(2'd3, 32'hF);

        // Falling-edge select on bit0.
        wr(2'd1, 32'h1);
        in_port = 4'h1;
        repeat (4) tick();
        rd(2'd3);
        chk("fall_no_rise_sel", rd0, 32'h0);
        chk("fall_any_both", rd1, 32'h3);
        wr(2'd3, 32'hF);
        in_port = 4'h0;
        repeat (4) tick();
        rd(2'd3);
        chk("fall_cap_sel", rd0, 32'h1);
        chk("fall_cap_any", rd1, 32'h1);
        rd(2'd1);
        chk("pol_rd_sel", rd0, 32'h1);
        chk("pol_rd_any", rd1, 32'h0);

        // Masking.
        wr(2'd3, 32'hF);
        wr(2'd2, 32'h0);
        in_port = 4'h8;
        repeat (4) tick();
        chk("mask_irq_off", 32'(irq0), 32'd0);
        rd(2'd3);
        chk("mask_cap", rd0, 32'h8);
        wr(2'd2, 32'h8);
        chk("mask_irq_on", 32'(irq0), 32'd1);

        // Random bus and input traffic against the model.
        repeat (400) begin
            if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
            address    = 2'($urandom);
            writedata  = $urandom;
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(0, 3) != 0);
            tick();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
